mahsqr_iter_sqrt: RTL

MAHSQR_ITER_SQRT -- requirements
Module: mahsqr_iter_sqrt

---
 rtl/mahsqr_iter_sqrt_if.sv | 24 ++
 rtl/mahsqr_iter_sqrt.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mahsqr_iter_sqrt_if.sv
// Radicand-in / root-out handshake bundle for mahsqr_iter_sqrt.
// The slave modport is the square-root block; the master is its user.
interface mahsqr_iter_sqrt_if #(
    parameter int W = 16
) ();
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_radicand;
    logic           in_mode;
    logic           out_valid;
    logic           out_ready;
    logic [W/2-1:0] out_root;
    logic           out_mode;

    modport slave (
        input  in_valid, in_radicand, in_mode, out_ready,
        output in_ready, out_valid, out_root, out_mode
    );

    modport master (
        output in_valid, in_radicand, in_mode, out_ready,
        input  in_ready, out_valid, out_root, out_mode
    );
endinterface

// File: rtl/mahsqr_iter_sqrt.sv
// Iterative restoring square root with an approximate mode.
// Exact mode computes floor(sqrt(R)) over W/2 cycles. Approximate mode takes
// the K leading bits of R (aligned on a bit pair), roots them in K/2 cycles,
// scales the root back up and adds a linear correction from the dropped bits.
module mahsqr_iter_sqrt #(
    parameter int W = 16,
    parameter int K = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    mahsqr_iter_sqrt_if.slave  bus,
    output logic               busy
);

    // Reject illegal widths at elaboration time.
    if ((W % 2) != 0 || W < 4 || (K % 2) != 0 || K < 2 || K > W) begin : g_bad_params
        $error("mahsqr_iter_sqrt: W must be even >= 4, K even with 2 <= K <= W");
    end

    localparam int RW = W/2 + 3;           // partial remainder incl. headroom
    localparam int HW = $clog2(W) + 1;     // root scale (s/2) width
    localparam int CW = $clog2(W/2) + 1;   // iteration counter width

    typedef enum logic [1:0] {IDLE, NORM, ITER, DONE} state_t;

    state_t          state;
    logic [W-1:0]    r_q;       // latched radicand
    logic            mode_q;    // latched mode
    logic [W-1:0]    shreg;     // operand, consumed two bits per cycle from the top
    logic [RW-1:0]   rem;       // partial remainder
    logic [W/2-1:0]  root;      // partial root
    logic [W-1:0]    y_q;       // bits dropped by normalisation
    logic [HW-1:0]   h_q;       // root scale-up amount, s/2 (0 when unused)
    logic [CW-1:0]   cnt;

    // Normalisation results, consumed in NORM.
    int              p;
    int              s;
    logic [W-1:0]    norm_op;
    logic [W-1:0]    norm_y;
    logic [HW-1:0]   norm_h;

    // One restoring-sqrt step plus the final scaled result.
    logic [RW-1:0]   rem_sh;
    logic [RW-1:0]   trial;
    logic [RW-1:0]   rem_nx;
    logic [W/2-1:0]  root_nx;
    logic [W-1:0]    res_w;
    logic [CW-1:0]   n_last;

    // Find the leading bit pair and build the operand, correction bits and scale.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        p       = 0;
        norm_op = '0;
        norm_y  = '0;
        norm_h  = '0;
        for (int i = 0; i < W/2; i++) begin
            if (r_q[2*i +: 2] != 2'b00) p = i;
        end
        s = 2*p + 2 - K;
        if (mode_q) begin
            norm_op = r_q;
        end else if (s > 0) begin
            // Keep the K leading bits, left-aligned so they are rooted first.
            norm_op = (r_q >> s) << (W - K);
            norm_y  = r_q & ~({W{1'b1}} << s);
            norm_h  = HW'(s / 2);
        end else begin
            // Short radicand: it fits in K bits, no correction.
            norm_op = r_q << (W - K);
        end
    end

    // Trial subtraction for the current root bit, and the scaled output value.
    always_comb begin
        n_last = mode_q ? CW'(W/2 - 1) : CW'(K/2 - 1);
        rem_sh = {rem[RW-3:0], shreg[W-1 -: 2]};
        trial  = {{(RW - W/2 - 2){1'b0}}, root, 2'b01};
        if (rem_sh >= trial) begin
            rem_nx  = rem_sh - trial;
            root_nx = {root[W/2-2:0], 1'b1};
        end else begin
            rem_nx  = rem_sh;
            root_nx = {root[W/2-2:0], 1'b0};
        end
        // With h_q = 0 and y_q = 0 (exact or short radicand) this reduces to the root.
        res_w = ({{(W/2){1'b0}}, root_nx} << h_q) + (y_q >> (h_q + HW'(K/2)));
    end

    // Control FSM with registered handshake outputs and the datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.out_root  <= '0;
            bus.out_mode  <= 1'b0;
            busy          <= 1'b0;
            r_q           <= '0;
            mode_q        <= 1'b0;
            shreg         <= '0;
            rem           <= '0;
            root          <= '0;
            y_q           <= '0;
            h_q           <= '0;
            cnt           <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            case (state)
                IDLE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        r_q          <= bus.in_radicand;
                        mode_q       <= bus.in_mode;
                        bus.in_ready <= 1'b0;
                        busy         <= 1'b1;
                        state        <= NORM;
                    end
                end
                NORM: begin
                    shreg <= norm_op;
                    y_q   <= norm_y;
                    h_q   <= norm_h;
                    rem   <= '0;
                    root  <= '0;
                    cnt   <= '0;
                    state <= ITER;
                end
                ITER: begin
                    shreg <= shreg << 2;
                    rem   <= rem_nx;
                    root  <= root_nx;
                    cnt   <= cnt + CW'(1);
                    if (cnt == n_last) begin
                        bus.out_root  <= res_w[W/2-1:0];
                        bus.out_mode  <= mode_q;
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
